bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter bus_width, default 32: width of every address and data field.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_raddr_valid in 1, i_raddr in bus_width, i_raddr_ready out 1: instruction read-address channel from the core.
REQ-005 i_rdata_valid out 1, i_rdata out bus_width, i_rdata_ready in 1: instruction read-data channel to the core.
REQ-006 d_raddr_valid in 1, d_raddr in bus_width, d_raddr_ready out 1: data read-address channel.
REQ-007 d_rdata_valid out 1, d_rdata out bus_width, d_rdata_ready in 1: data read-data channel.
REQ-008 d_waddr_valid in 1, d_waddr in bus_width, d_waddr_ready out 1: data write-address channel.
REQ-009 d_wdata_valid in 1, d_wdata in bus_width, d_wdata_ready out 1: data write-data channel.
REQ-010 m_raddr_valid out 1, m_raddr out bus_width, m_raddr_ready in 1: memory read-address channel.
REQ-011 m_rdata_valid in 1, m_rdata in bus_width, m_rdata_ready out 1: memory read-data channel.
REQ-012 m_waddr_valid/m_waddr out 1/bus_width, m_waddr_ready in 1; m_wdata_valid/m_wdata out 1/bus_width, m_wdata_ready in 1: memory write channels.

Function
REQ-013 Every channel handshake completes in a cycle where valid and ready are both 1 at the rising edge.
REQ-014 The block SHALL have exactly one transaction outstanding; states IDLE, RADDR, RDATA, WRITE.
REQ-015 Requests in IDLE: IR = i_raddr_valid; DR = d_raddr_valid; DW = d_waddr_valid && d_wdata_valid.
REQ-016 D side: DW beats DR when both are asserted; the D request is DW||DR.
REQ-017 I vs D: round-robin; if both request, the side not granted last wins; a lone requester always wins; last-grant pointer resets to D (I wins first tie).
REQ-018 Grant cycle (IDLE only): the winner's ready(s) are 1 for exactly that cycle (i_raddr_ready, d_raddr_ready, or d_waddr_ready with d_wdata_ready together); address/data are latched; next state is RADDR (reads) or WRITE.
REQ-019 All core-side ready outputs are 0 outside the grant cycle.
REQ-020 RADDR: m_raddr_valid=1, m_raddr=latched address; on handshake -> RDATA.
REQ-021 RDATA: owner rdata_valid=m_rdata_valid, owner rdata=m_rdata (combinational), m_rdata_ready=owner rdata_ready; non-owner rdata_valid=0; on handshake -> IDLE.
REQ-022 WRITE: m_waddr_valid=!aw_done, m_wdata_valid=!w_done, with latched values; done flags set on their handshakes; -> IDLE when both are done, including both done in the same cycle.
REQ-023 m_rdata_ready=0 outside RDATA; m_rdata_valid outside RDATA is ignored and never forwarded.
REQ-024 Latency: grant at cycle N, m_raddr_valid at N+1; with zero-wait memory, rdata reaches the core at N+2 and the next grant can occur at N+3.
REQ-025 A request deasserted before its grant cycle is not remembered.

Reset
REQ-026 While rst=1 the block SHALL be in IDLE with all valid and ready outputs 0, done flags 0, latches 0, and the pointer at D; this applies immediately, even mid-transaction, and the in-flight transaction is dropped.
REQ-027 The first grant can occur in the first cycle after rst falls.

Structure
REQ-028 The state encoding, the owner encoding (OWN_I, OWN_DR, OWN_DW) and the bus_width default SHALL live in the shared copperv bus package/header.
REQ-029 The two-way round-robin selection SHALL be one sub-module, rr_arb2 (req_i, req_d, grant, registered pointer).

Verification
REQ-030 Lone I read, addr 0x0000_0004, memory ready immediately, returns 0x0000_0013 -> i_raddr_ready pulses once, m_raddr=0x4 one cycle later, i_rdata=0x13 with i_rdata_valid high for one cycle.
REQ-031 IR and DR both held from reset -> grants alternate I, D, I, D; the D read to 0x100 is never starved.
REQ-032 DW (addr 0x200, data 0xDEADBEEF) with DR pending -> write granted first; m_waddr_ready at cycle +1 and m_wdata_ready at +3 -> returns to IDLE only after +3.
REQ-033 m_rdata_valid pulsed in IDLE and RADDR -> no core-side rdata_valid and m_rdata_ready stays 0.
REQ-034 rst asserted in RDATA -> all valid and ready outputs go 0 without a clock edge; after release the next IR is granted normally.
REQ-035 i_rdata_ready held 0 for 5 cycles in RDATA -> m_rdata_ready is 0 and the state holds; on release the data is delivered once.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared bus definitions for the copperv bus arbiter: the
//                default bus width, the arbiter state encoding and the
//                encoding of the transaction owner.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Default width of every address and data field
    localparam int BUS_WIDTH_DEFAULT = 32;

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RADDR = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // Owner of the single outstanding transaction
    localparam logic [1:0] OWN_I  = 2'd0;
    localparam logic [1:0] OWN_DR = 2'd1;
    localparam logic [1:0] OWN_DW = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin selector between the instruction side
//                and the data side. A lone requester always wins; on a tie
//                the side not granted last wins. The pointer resets to D so
//                that I wins the first tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req_i,
    input  logic       req_d,
    output logic [1:0] grant      // [0] = I side, [1] = D side
);

    logic r_last_d;
    logic w_pick_i;

    // Pick a winner: I wins when alone or when D was granted last
    always_comb begin
        w_pick_i = req_i && (!req_d || r_last_d);
        grant[0] = en && w_pick_i;
        grant[1] = en && req_d && !w_pick_i;
    end

    // Remember which side took the most recent grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (grant[0] || grant[1]) begin
            r_last_d <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Arbitrates the copperv instruction read port and the data
//                read/write ports onto a single memory bus with exactly one
//                transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int bus_width = BUS_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction read-address / read-data
    input  logic                 i_raddr_valid,
    input  logic [bus_width-1:0] i_raddr,
    output logic                 i_raddr_ready,
    output logic                 i_rdata_valid,
    output logic [bus_width-1:0] i_rdata,
    input  logic                 i_rdata_ready,
    // data read-address / read-data
    input  logic                 d_raddr_valid,
    input  logic [bus_width-1:0] d_raddr,
    output logic                 d_raddr_ready,
    output logic                 d_rdata_valid,
    output logic [bus_width-1:0] d_rdata,
    input  logic                 d_rdata_ready,
    // data write-address / write-data
    input  logic                 d_waddr_valid,
    input  logic [bus_width-1:0] d_waddr,
    output logic                 d_waddr_ready,
    input  logic                 d_wdata_valid,
    input  logic [bus_width-1:0] d_wdata,
    output logic                 d_wdata_ready,
    // memory read channels
    output logic                 m_raddr_valid,
    output logic [bus_width-1:0] m_raddr,
    input  logic                 m_raddr_ready,
    input  logic                 m_rdata_valid,
    input  logic [bus_width-1:0] m_rdata,
    output logic                 m_rdata_ready,
    // memory write channels
    output logic                 m_waddr_valid,
    output logic [bus_width-1:0] m_waddr,
    input  logic                 m_waddr_ready,
    output logic                 m_wdata_valid,
    output logic [bus_width-1:0] m_wdata,
    input  logic                 m_wdata_ready
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [1:0]           r_owner;
    logic [bus_width-1:0] r_addr;
    logic [bus_width-1:0] r_wdata;
    logic                 r_aw_done;
    logic                 r_w_done;

    logic                 w_req_dw;
    logic                 w_arb_en;
    logic [1:0]           w_grant;
    logic                 w_load;
    logic [1:0]           w_load_owner;
    logic [bus_width-1:0] w_load_addr;
    logic [bus_width-1:0] w_load_wdata;
    logic                 w_aw_done_next;
    logic                 w_w_done_next;
    logic                 w_aw_hs;
    logic                 w_w_hs;

    // A write needs both of its channels presented to count as a request
    assign w_req_dw = d_waddr_valid && d_wdata_valid;
    // Grants only happen in IDLE, and never while reset is held
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en    (w_arb_en),
        .req_i (i_raddr_valid),
        .req_d (w_req_dw || d_raddr_valid),
        .grant (w_grant)
    );

    // Next-state and output decode for the single outstanding transaction
    always_comb begin
        w_state_next   = r_state;
        w_load         = 1'b0;
        w_load_owner   = OWN_I;
        w_load_addr    = '0;
        w_load_wdata   = '0;
        w_aw_done_next = r_aw_done;
        w_w_done_next  = r_w_done;
        w_aw_hs        = 1'b0;
        w_w_hs         = 1'b0;
        i_raddr_ready  = 1'b0;
        d_raddr_ready  = 1'b0;
        d_waddr_ready  = 1'b0;
        d_wdata_ready  = 1'b0;
        i_rdata_valid  = 1'b0;
        i_rdata        = '0;
        d_rdata_valid  = 1'b0;
        d_rdata        = '0;
        m_raddr_valid  = 1'b0;
        m_raddr        = r_addr;
        m_rdata_ready  = 1'b0;
        m_waddr_valid  = 1'b0;
        m_waddr        = r_addr;
        m_wdata_valid  = 1'b0;
        m_wdata        = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_grant[0]) begin
                    i_raddr_ready = 1'b1;
                    w_load        = 1'b1;
                    w_load_owner  = OWN_I;
                    w_load_addr   = i_raddr;
                    w_state_next  = ST_RADDR;
                end else if (w_grant[1]) begin
                    w_load = 1'b1;
                    if (w_req_dw) begin
                        // A pending write beats a pending read on the D side
                        d_waddr_ready = 1'b1;
                        d_wdata_ready = 1'b1;
                        w_load_owner  = OWN_DW;
                        w_load_addr   = d_waddr;
                        w_load_wdata  = d_wdata;
                        w_state_next  = ST_WRITE;
                    end else begin
                        d_raddr_ready = 1'b1;
                        w_load_owner  = OWN_DR;
                        w_load_addr   = d_raddr;
                        w_state_next  = ST_RADDR;
                    end
                end
            end
            ST_RADDR: begin
                m_raddr_valid = 1'b1;
                if (m_raddr_ready) begin
                    w_state_next = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_owner == OWN_I) begin
                    i_rdata_valid = m_rdata_valid;
                    i_rdata       = m_rdata;
                    m_rdata_ready = i_rdata_ready;
                end else begin
                    d_rdata_valid = m_rdata_valid;
                    d_rdata       = m_rdata;
                    m_rdata_ready = d_rdata_ready;
                end
                if (m_rdata_valid && m_rdata_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Address and data may complete in either order or together
                m_waddr_valid  = !r_aw_done;
                m_wdata_valid  = !r_w_done;
                w_aw_hs        = !r_aw_done && m_waddr_ready;
                w_w_hs         = !r_w_done && m_wdata_ready;
                w_aw_done_next = r_aw_done || w_aw_hs;
                w_w_done_next  = r_w_done || w_w_hs;
                if (w_aw_done_next && w_w_done_next) begin
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register, transaction latches and write completion flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_I;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
            if (w_load) begin
                r_owner <= w_load_owner;
                r_addr  <= w_load_addr;
                if (w_load_owner == OWN_DW) begin
                    r_wdata <= w_load_wdata;
                end
            end
        end
    end

endmodule
`default_nettype wire
